// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage hazard control bundle: decoder-side request fields and
// the forwarding/stall/flush controls returned to the pipeline.
interface pipeline_hazard_ctrl_if #(
  parameter int NUM_FWD_STAGES = 2
);
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_wreg;
  logic             id_m2reg;
  logic             id_multicycle;
  logic             ex_redirect;
  logic [SEL_W-1:0] qa_sel;
  logic [SEL_W-1:0] qb_sel;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             mc_busy;
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_rd, id_wreg, id_m2reg, id_multicycle, ex_redirect,
    input  qa_sel, qb_sel, pc_stall, ifid_stall, idex_bubble,
    input  ifid_flush, mc_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_rd, id_wreg, id_m2reg, id_multicycle, ex_redirect,
    output qa_sel, qb_sel, pc_stall, ifid_stall, idex_bubble,
    output ifid_flush, mc_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Data-hazard, load-use, multi-cycle and redirect control for ID.
// Optional perf counters: define HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_STAGE     = 1,
  parameter int MC_CYCLES      = 4
) (
  input logic                          clk,
  input logic                          rst_n,
  pipeline_hazard_ctrl_if.slave        hz
);
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
  localparam bit MC_EN = (MC_CYCLES > 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wreg;
    logic       m2reg;
  } shd_t;

  typedef enum logic {IDLE, MC_WAIT} st_t;

  shd_t             sh_q [NUM_FWD_STAGES];
  st_t              st_q, st_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             lu_a, lu_b, lu;
  logic             fsm_hold, hazard, redir, issue;
  logic             pc_stall_w, flush_w;

  function automatic logic hit(shd_t e, logic [4:0] rs, logic use_s);
    return e.valid & e.wreg & (e.rd == rs) & (rs != 5'd0) & use_s;
  endfunction

  // Scan oldest to youngest so the youngest match is written last.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (hit(sh_q[k], hz.id_rs1, hz.id_use_rs1)) begin
        sel_a = SEL_W'(k + 1);
        lu_a  = sh_q[k].m2reg && (k < LOAD_STAGE);
      end
      if (hit(sh_q[k], hz.id_rs2, hz.id_use_rs2)) begin
        sel_b = SEL_W'(k + 1);
        lu_b  = sh_q[k].m2reg && (k < LOAD_STAGE);
      end
    end
  end

  assign lu    = hz.id_valid & (lu_a | lu_b);
  assign redir = hz.ex_redirect;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    fsm_hold = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (hz.id_valid && hz.id_multicycle && !lu && MC_EN) begin
          st_d     = MC_WAIT;
          cnt_d    = 8'(MC_CYCLES - 1);
          fsm_hold = 1'b1;
        end
      end
      MC_WAIT: begin
        if (cnt_q > 8'd1) begin
          cnt_d    = cnt_q - 8'd1;
          fsm_hold = 1'b1;
        end else begin
          st_d  = IDLE;
          cnt_d = 8'd0;
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = 8'd0;
      end
    endcase
    if (redir) begin
      st_d  = IDLE;
      cnt_d = 8'd0;
    end
  end

  assign hazard     = lu | fsm_hold;
  assign issue      = hz.id_valid & ~hazard & ~redir;
  assign pc_stall_w = rst_n & hazard & ~redir;
  assign flush_w    = rst_n & redir;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_FWD_STAGES; k++) sh_q[k] <= '0;
      st_q  <= IDLE;
      cnt_q <= 8'd0;
    end else begin
      sh_q[0] <= issue ? shd_t'{1'b1, hz.id_rd, hz.id_wreg, hz.id_m2reg}
                       : '0;
      for (int k = 1; k < NUM_FWD_STAGES; k++) sh_q[k] <= sh_q[k-1];
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign hz.qa_sel      = rst_n ? sel_a : '0;
  assign hz.qb_sel      = rst_n ? sel_b : '0;
  assign hz.pc_stall    = pc_stall_w;
  assign hz.ifid_stall  = pc_stall_w;
  assign hz.idex_bubble = rst_n & (hazard | redir);
  assign hz.ifid_flush  = flush_w;
  assign hz.mc_busy     = rst_n & (st_q == MC_WAIT);

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (pc_stall_w && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_w && flush_cnt_q != 32'hFFFF_FFFF)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif
endmodule
